// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, instr} with show-ahead head and flush on branch redirect.
// Optional INSTR_QUEUE_STATS_EN adds saturating stall_cycles / flush_count outputs.
module instr_queue #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       take_branch,
    input  T                           instr_from_fetch,
    input  T                           pc_from_fetch,
    input  logic                       valid_from_fetch,
    output logic                       ready_to_fetch,
    output T                           instr_to_decode,
    output T                           pc_to_decode,
    output logic                       valid_to_decode,
    input  logic                       ready_from_decode,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef INSTR_QUEUE_STATS_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                flush_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    T pc_mem    [DEPTH];
    T instr_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Ready depends only on registered occupancy, so a full queue cannot accept even when decode pops.
    assign ready_to_fetch  = (count != FULL_COUNT) && !reset;
    assign valid_to_decode = (count != '0);
    assign push = valid_from_fetch && ready_to_fetch && !take_branch;
    assign pop  = valid_to_decode && ready_from_decode && !take_branch;

    assign pc_to_decode    = valid_to_decode ? pc_mem[rd_ptr]    : '0;
    assign instr_to_decode = valid_to_decode ? instr_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc_from_fetch;
            instr_mem[wr_ptr] <= instr_from_fetch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || take_branch) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef INSTR_QUEUE_STATS_EN
    // Counters survive take_branch so redirect statistics accumulate across flushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (valid_from_fetch && !ready_to_fetch && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (take_branch && (flush_count != '1))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
